// File: rtl/serial_paralelo_rx_if.sv
// Serial lane bundle: one-bit serial input plus the deserialised byte outputs.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       byte_strobe;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  byte_strobe
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active,
    output byte_strobe
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: MSB-first deserialiser that byte-aligns on four
// consecutive 8'hBC COM symbols, then delivers every non-COM byte.
module serial_paralelo_rx (
  input  logic                 clk_8f,
  input  logic                 reset,
  serial_paralelo_rx_if.slave  bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [BYTE_W-1:0] COM      = 8'hBC;
  localparam logic [CNT_W-1:0]  BIT_LAST = 3'd7;
  localparam logic [CNT_W-1:0]  COM_LOCK = 3'd4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [BYTE_W-2:0]   r_shift;
  logic [CNT_W-1:0]    r_bit_cnt,  w_bit_cnt_nxt;
  logic [CNT_W-1:0]    r_com_cnt,  w_com_cnt_nxt;
  logic [BYTE_W-1:0]   r_data_out, w_data_nxt;
  logic                r_valid,    w_valid_nxt;
  logic                r_active,   w_active_nxt;
  logic                r_strobe,   w_strobe_nxt;

  logic [BYTE_W-1:0]   w_cand;
  logic                w_is_com;
  logic                w_boundary;
  logic [CNT_W-1:0]    w_com_inc;

  // Only the low 7 bits of history are needed; the incoming bit completes the byte.
  assign w_cand     = {r_shift, bus.data_in};
  assign w_is_com   = (w_cand == COM);
  assign w_boundary = (r_bit_cnt == BIT_LAST);
  assign w_com_inc  = r_com_cnt + 3'd1;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_state    <= SEARCH;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_com_cnt  <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_cand[BYTE_W-2:0];
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_com_cnt  <= w_com_cnt_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_active   <= w_active_nxt;
      r_strobe   <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_com_cnt_nxt = r_com_cnt;
    w_data_nxt    = r_data_out;
    w_valid_nxt   = r_valid;
    w_active_nxt  = r_active;
    w_strobe_nxt  = 1'b0;

    case (r_state)
      SEARCH: begin
        // Sliding alignment: any bit offset may start a COM run.
        w_bit_cnt_nxt = r_bit_cnt;
        w_data_nxt    = '0;
        w_valid_nxt   = 1'b0;
        w_active_nxt  = 1'b0;
        if (w_is_com) begin
          w_bit_cnt_nxt = '0;
          w_com_cnt_nxt = 3'd1;
          w_state_nxt   = COUNT;
        end
      end

      COUNT: begin
        w_data_nxt   = '0;
        w_valid_nxt  = 1'b0;
        w_active_nxt = 1'b0;
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt_nxt = w_com_inc;
            if (w_com_inc == COM_LOCK) begin
              w_state_nxt  = ACTIVE;
              w_active_nxt = 1'b1;
            end
          end else begin
            w_com_cnt_nxt = '0;
            w_state_nxt   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        w_active_nxt = 1'b1;
        if (w_boundary) begin
          w_strobe_nxt = 1'b1;
          if (w_is_com) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_cand;
            w_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt   = SEARCH;
        w_bit_cnt_nxt = '0;
        w_com_cnt_nxt = '0;
        w_data_nxt    = '0;
        w_valid_nxt   = 1'b0;
        w_active_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.data_out    = r_data_out;
  assign bus.valid_out   = r_valid;
  assign bus.active      = r_active;
  assign bus.byte_strobe = r_strobe;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed lock/unlock scenarios plus randomized
// streams, each cycle compared against a bit-history reference model.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;

  logic clk_8f;
  logic reset;

  serial_paralelo_rx_if bus ();

  serial_paralelo_rx dut (
    .clk_8f (clk_8f),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  int   n_checks;
  int   n_errors;
  int   strobe_cnt;
  bit   valid_seen;
  logic bits_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Byte seen by the receiver ending at sampled bit i (pre-reset history is zero).
  function automatic logic [7:0] win(input int i);
    logic [7:0] w;
    int idx;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      idx = i - 7 + k;
      w = {w[6:0], (idx >= 0) ? bits_q[idx] : 1'b0};
    end
    return w;
  endfunction

  // Edge index of the 4th aligned COM, or -1 if not locked within n sampled bits.
  function automatic int lock_edge(input int n);
    int  s;
    int  i;
    int  j;
    bit  broken;
    s = 0;
    while (s < n) begin
      i = s;
      while (i < n && win(i) != COM) i++;
      if (i >= n) return -1;
      broken = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        j = i + 8 * k;
        if (j >= n) return -1;
        if (win(j) != COM) begin
          s = j + 1;
          broken = 1'b1;
          break;
        end
      end
      if (!broken) return i + 24;
    end
    return -1;
  endfunction

  task automatic model(output logic [7:0] e_data, output logic e_valid,
                       output logic e_active, output logic e_strobe);
    int n;
    int last;
    int lk;
    logic [7:0] w;
    n = bits_q.size();
    last = n - 1;
    lk = lock_edge(n);
    e_data = '0; e_valid = 1'b0; e_active = 1'b0; e_strobe = 1'b0;
    if (lk >= 0 && lk <= last) begin
      e_active = 1'b1;
      e_strobe = (last > lk) && (((last - lk) % 8) == 0);
      for (int m = lk + 8; m <= last; m += 8) begin
        w = win(m);
        if (w != COM) begin
          e_data  = w;
          e_valid = 1'b1;
        end else begin
          e_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_data;
    logic e_valid, e_active, e_strobe;
    model(e_data, e_valid, e_active, e_strobe);
    chk("data_out",    32'(bus.data_out),    32'(e_data));
    chk("valid_out",   32'(bus.valid_out),   32'(e_valid));
    chk("active",      32'(bus.active),      32'(e_active));
    chk("byte_strobe", 32'(bus.byte_strobe), 32'(e_strobe));
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_8f);
    bus.data_in = b;
    @(posedge clk_8f);
    bits_q.push_back(b);
    #1;
    if (bus.byte_strobe === 1'b1) strobe_cnt++;
    if (bus.valid_out === 1'b1) valid_seen = 1'b1;
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic [7:0] t;
    t = v;
    for (int i = 7; i >= 0; i--) send_bit(t[i]);
  endtask

  // Called 1 time unit after a rising edge; reset lands between clock edges.
  task automatic apply_reset();
    #1;
    reset = 1'b0;
    #1;
    chk("rst_data_out",    32'(bus.data_out),    32'd0);
    chk("rst_valid_out",   32'(bus.valid_out),   32'd0);
    chk("rst_active",      32'(bus.active),      32'd0);
    chk("rst_byte_strobe", 32'(bus.byte_strobe), 32'd0);
    bits_q.delete();
    repeat (2) @(posedge clk_8f);
    #2;
    reset = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int ncom;
    n_checks   = 0;
    n_errors   = 0;
    strobe_cnt = 0;
    valid_seen = 1'b0;
    bus.data_in = 1'b0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("por_data_out", 32'(bus.data_out),  32'd0);
    chk("por_active",   32'(bus.active),    32'd0);
    check_outputs();
    @(posedge clk_8f);
    #2 reset = 1'b1;
    #1;

    // Three COMs then a non-COM byte must fall back to search.
    valid_seen = 1'b0;
    repeat (3) send_byte(COM);
    send_byte(8'h55);
    chk("s30_active", 32'(bus.active), 32'd0);
    chk("s30_valid_seen", 32'(valid_seen), 32'd0);
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));

    // Misaligned start, lock, then two data bytes.
    apply_reset();
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    repeat (4) send_byte(COM);
    chk("s31_active", 32'(bus.active), 32'd1);
    strobe_cnt = 0;
    send_byte(8'hA5);
    chk("s31_data_a5", 32'(bus.data_out), 32'hA5);
    chk("s31_valid_a5", 32'(bus.valid_out), 32'd1);
    send_byte(8'h3C);
    chk("s31_data_3c", 32'(bus.data_out), 32'h3C);
    chk("s31_valid_3c", 32'(bus.valid_out), 32'd1);
    chk("s31_strobes", 32'(strobe_cnt), 32'd2);

    // Idle COM between data holds data_out and drops valid_out.
    send_byte(8'h12);
    chk("s32_valid_12", 32'(bus.valid_out), 32'd1);
    send_byte(COM);
    chk("s32_data_hold", 32'(bus.data_out), 32'h12);
    chk("s32_valid_idle", 32'(bus.valid_out), 32'd0);
    send_byte(8'h34);
    chk("s32_data_34", 32'(bus.data_out), 32'h34);
    chk("s32_valid_34", 32'(bus.valid_out), 32'd1);

    // All-zero and all-one bytes are ordinary data.
    send_byte(8'h00);
    chk("s33_data_00", 32'(bus.data_out), 32'h00);
    chk("s33_valid_00", 32'(bus.valid_out), 32'd1);
    send_byte(8'hFF);
    chk("s33_data_ff", 32'(bus.data_out), 32'hFF);
    chk("s33_valid_ff", 32'(bus.valid_out), 32'd1);
    chk("s33_active", 32'(bus.active), 32'd1);

    // Reset mid-byte while locked, then re-lock needs four fresh COMs.
    b = 8'h9A;
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    apply_reset();
    repeat (3) send_byte(COM);
    chk("s34_active_3com", 32'(bus.active), 32'd0);
    send_byte(COM);
    chk("s34_active_4com", 32'(bus.active), 32'd1);

    // Lock at a 5-bit offset and decode following bytes.
    apply_reset();
    repeat (5) send_bit(1'($urandom_range(0, 1)));
    repeat (4) send_byte(COM);
    chk("s35_active", 32'(bus.active), 32'd1);
    send_byte(8'hD7);
    chk("s35_data_d7", 32'(bus.data_out), 32'hD7);
    send_byte(8'h2E);
    chk("s35_data_2e", 32'(bus.data_out), 32'h2E);

    // Randomized streams: noise, a COM run of random length, mixed data/idle bytes.
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      repeat ($urandom_range(0, 20)) send_bit(1'($urandom_range(0, 1)));
      ncom = $urandom_range(3, 5);
      repeat (ncom) send_byte(COM);
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 4) == 0) b = COM;
        else b = 8'($urandom);
        send_byte(b);
        if (k == 12 && $urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 7)) send_bit(1'($urandom_range(0, 1)));
          apply_reset();
          repeat (4) send_byte(COM);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 The block SHALL have no parameters; byte width is fixed at 8 and the COM symbol is fixed at 8'hBC.
REQ-002 Port: clk_8f  input  1  bit clock; all state SHALL change only on its rising edge or on reset.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 Port: data_in  input  1  serial bit stream from the TX parallel-to-serial lane, MSB first.
REQ-005 Port: data_out  output  8  last received non-COM byte.
REQ-006 Port: valid_out  output  1  data_out holds a byte received in the current byte period.
REQ-007 Port: active  output  1  byte alignment locked.
REQ-008 Port: byte_strobe  output  1  one-cycle pulse per aligned byte boundary while active.

Function
REQ-009 The block SHALL shift data_in into an 8-bit register each clk_8f edge, MSB first.
REQ-010 The candidate byte SHALL be defined as {shift[6:0], data_in} at the sampling edge.
REQ-011 The block SHALL implement the FSM states SEARCH, COUNT and ACTIVE.
REQ-012 In SEARCH, bit alignment SHALL slide: the candidate byte is compared against 8'hBC every cycle.
REQ-013 On a match in SEARCH, the block SHALL clear the 3-bit bit counter to 0, set the COM count to 1 and go to COUNT.
REQ-014 Outside SEARCH, the bit counter SHALL increment each cycle and wrap 7->0.
REQ-015 A byte boundary SHALL be the edge at which the bit counter equals 7.
REQ-016 In COUNT at a boundary, a candidate byte of 8'hBC SHALL increment the COM count.
REQ-017 In COUNT, when the COM count reaches 4 (four consecutive aligned COMs), the block SHALL go to ACTIVE at that edge.
REQ-018 In COUNT at a boundary, a candidate byte other than 8'hBC SHALL clear the COM count and return the block to SEARCH; the next match search starts on the following cycle.
REQ-019 While in SEARCH or COUNT, data_out SHALL be 0 and valid_out, byte_strobe and active SHALL be 0.
REQ-020 In ACTIVE, active SHALL be 1, registered, and SHALL assert on the cycle after the 4th COM boundary.
REQ-021 In ACTIVE at each boundary, byte_strobe SHALL pulse high for exactly the following cycle.
REQ-022 In ACTIVE at a boundary with a candidate byte other than 8'hBC, data_out SHALL load the candidate and valid_out SHALL be set to 1.
REQ-023 In ACTIVE at a boundary with a candidate byte of 8'hBC (idle), valid_out SHALL be set to 0 and data_out SHALL hold its previous value.
REQ-024 data_out and valid_out SHALL hold between boundaries, giving 1-cycle latency from the LSB bit edge to a registered output.
REQ-025 ACTIVE SHALL persist regardless of data content and SHALL be left only by reset.
REQ-026 A 0x00 or 0xFF data byte in ACTIVE SHALL be passed as valid data; only 8'hBC is treated as idle.

Reset
REQ-027 While reset=0, the block SHALL immediately, independent of clk_8f, clear the shift register, bit counter and COM count, and enter SEARCH with data_out=0, valid_out=0, active=0 and byte_strobe=0.
REQ-028 Reset asserted mid-byte or in ACTIVE SHALL discard the partial byte and the lock.
REQ-029 After reset deassertion, the first edge SHALL sample data_in normally in SEARCH.

Verification
REQ-030 Scenario: drive 3 aligned 0xBC bytes followed by 0x55 -> the block returns to SEARCH, active stays 0 and valid_out is never 1.
REQ-031 Scenario: drive 3 random bits, then 4 x 0xBC, then 0xA5 and 0x3C -> active=1 one cycle after the 4th COM, data_out=0xA5 with valid_out=1, then data_out=0x3C with valid_out=1, one byte_strobe per byte.
REQ-032 Scenario: when locked, drive 0x12, 0xBC, 0x34 -> valid_out sequence 1, 0, 1 at boundaries; data_out holds 0x12 during the 0xBC period.
REQ-033 Scenario: when locked, drive 0x00 then 0xFF -> both bytes are delivered with valid_out=1; active stays 1.
REQ-034 Scenario: assert reset 4 bits into a data byte while active -> all outputs read 0 immediately without a clock edge; re-lock requires 4 new COMs.
REQ-035 Scenario: drive a COM pattern starting on a non-byte-aligned bit offset (e.g. 5 pad bits) -> the block locks to that offset and subsequent bytes are decoded correctly.
